// File: rtl/leakyrelu_pkg.sv
// Shared encodings, FP32 constants and the sideband record for leakyrelu_vector_unit.
// The lane activation rule lives here so the datapath and any future users agree on it.
package leakyrelu_pkg;

  localparam int LANE_W = 32;
  localparam int LANES  = 4;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_RELU   = 2'd1;
  localparam logic [1:0] MODE_LRELU  = 2'd2;

  localparam logic [31:0] FP_ZERO       = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_ALPHA = 32'h3DCC_CCCD;

  typedef struct packed {
    logic                    valid;
    logic [1:0]              mode;
    logic [LANES-1:0]        sign;
    logic [LANES*LANE_W-1:0] raw;
  } sideband_t;

  // Unknown mode 3 falls through to bypass.
  function automatic logic [LANE_W-1:0] activate(input logic [1:0] mode, input logic sign,
                                                 input logic [LANE_W-1:0] raw,
                                                 input logic [LANE_W-1:0] prod);
    case (mode)
      MODE_RELU:  activate = sign ? FP_ZERO : raw;
      MODE_LRELU: activate = sign ? prod : raw;
      default:    activate = raw;
    endcase
  endfunction

endpackage

// File: rtl/leakyrelu_vector_unit_fifo.sv
// activation_out_fifo: circular buffer with a registered output stage; count includes
// the output register. activation_out_fifo_chk flags a push into a full buffer.
module activation_out_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       o_ready,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    mem_count_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             pop_s;
  logic             load_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_s  = out_valid_r & o_ready;
  assign load_s = (mem_count_r != '0) & (~out_valid_r | pop_s);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_r] <= push_data;
  end

  // The output register refills from storage; when nothing is left it returns to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      mem_count_r <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (load_s) begin
        out_data_r  <= mem[rd_ptr_r];
        out_valid_r <= 1'b1;
        rd_ptr_r    <= ptr_inc(rd_ptr_r);
      end else if (pop_s) begin
        out_data_r  <= '0;
        out_valid_r <= 1'b0;
      end
      mem_count_r <= mem_count_r + CW'(push) - CW'(load_s);
    end
  end

  assign o_valid = out_valid_r;
  assign o_data  = out_data_r;
  assign count   = mem_count_r + CW'(out_valid_r);

  activation_out_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .mem_count(mem_count_r)
  );

endmodule

module activation_out_fifo_chk #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic [CW-1:0] mem_count
);

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
                                   !(push && mem_count == CW'(DEPTH)))
    else $error("activation_out_fifo: push into full buffer");

endmodule

// File: rtl/multiplier_floating_point32.sv
// Fixed-latency FP32 multiplier: round-to-nearest-even, subnormals flushed to zero,
// overflow saturates to infinity. The result emerges LATENCY cycles after the inputs.
module multiplier_floating_point32 #(
  parameter int LATENCY = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  output logic        valid_out,
  output logic [31:0] out
);

  logic [47:0] prod_s;
  logic [9:0]  exp_s;
  logic [23:0] mant_s;
  logic        guard_s;
  logic        sticky_s;
  logic        sign_s;
  logic [31:0] result_s;
  logic [31:0] data_r [LATENCY];
  logic [LATENCY-1:0] valid_r;

  // exp_s is biased and may go negative (bit 9 set) on underflow.
  always_comb begin
    sign_s = inA[31] ^ inB[31];
    prod_s = {24'd0, 1'b1, inA[22:0]} * {24'd0, 1'b1, inB[22:0]};
    exp_s  = {2'b00, inA[30:23]} + {2'b00, inB[30:23]} - 10'd127;
    if (prod_s[47]) begin
      mant_s   = {1'b0, prod_s[46:24]};
      guard_s  = prod_s[23];
      sticky_s = |prod_s[22:0];
      exp_s    = exp_s + 10'd1;
    end else begin
      mant_s   = {1'b0, prod_s[45:23]};
      guard_s  = prod_s[22];
      sticky_s = |prod_s[21:0];
    end
    if (guard_s && (sticky_s || mant_s[0])) begin
      mant_s = mant_s + 24'd1;
    end else begin
      mant_s = mant_s;
    end
    if (mant_s[23]) begin
      mant_s = 24'd0;
      exp_s  = exp_s + 10'd1;
    end else begin
      exp_s  = exp_s;
    end
    if (inA[30:23] == 8'hFF || inB[30:23] == 8'hFF) begin
      result_s = {sign_s, 8'hFF, 23'd0};
    end else if (inA[30:23] == 8'd0 || inB[30:23] == 8'd0) begin
      result_s = {sign_s, 31'd0};
    end else if (exp_s[9] || exp_s == 10'd0) begin
      result_s = {sign_s, 31'd0};
    end else if (exp_s >= 10'd255) begin
      result_s = {sign_s, 8'hFF, 23'd0};
    end else begin
      result_s = {sign_s, exp_s[7:0], mant_s[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_r <= '0;
      for (int i = 0; i < LATENCY; i++) data_r[i] <= 32'd0;
    end else begin
      valid_r   <= {valid_r[LATENCY-2:0], valid_in};
      data_r[0] <= result_s;
      for (int i = 1; i < LATENCY; i++) data_r[i] <= data_r[i-1];
    end
  end

  assign out       = data_r[LATENCY-1];
  assign valid_out = valid_r[LATENCY-1];

endmodule

// File: rtl/leakyrelu_vector_unit.sv
// Multi-lane FP32 bypass/ReLU/LeakyReLU stage with credit-controlled output FIFO.
// Optional macro LRELU_NEG_COUNT_EN enables the saturating negative-lane counter.
module leakyrelu_vector_unit #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          NUM_CH        = 4,
  parameter int          MUL_LATENCY   = 7,
  parameter int          FIFO_DEPTH    = 8,
  parameter logic [31:0] DEFAULT_ALPHA = leakyrelu_pkg::DEFAULT_ALPHA
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  input  logic [1:0]                   i_mode,
  input  logic                         cfg_alpha_we,
  input  logic [DATA_WIDTH-1:0]        cfg_alpha,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
  output logic [31:0]                  o_neg_count
);

  import leakyrelu_pkg::*;

  localparam int BW = NUM_CH * DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = CW + 1;

  if (FIFO_DEPTH < MUL_LATENCY + 1) begin : g_depth_err
    $error("FIFO_DEPTH must be at least MUL_LATENCY+1");
  end
  if (NUM_CH != LANES || DATA_WIDTH != LANE_W) begin : g_shape_err
    $error("NUM_CH/DATA_WIDTH must match leakyrelu_pkg lane shape");
  end

  logic [DATA_WIDTH-1:0] alpha_r;
  logic                  i_ready_r;
  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic [NUM_CH-1:0]     signs_s;
  logic [BW-1:0]         prod_s;
  logic [BW-1:0]         push_data_s;
  logic [NUM_CH-1:0]     mul_valid_unused;
  logic [CW-1:0]         fifo_count_s;
  logic [TW-1:0]         inflight_s;
  logic [TW-1:0]         total_next_s;
  sideband_t             sb_in_s;
  sideband_t             sb_r [MUL_LATENCY];

  assign accept_s = i_valid & i_ready_r;
  assign pop_s    = o_valid & o_ready;
  assign push_s   = sb_r[MUL_LATENCY-1].valid;
  assign i_ready  = i_ready_r;

  always_comb begin
    signs_s = '0;
    for (int k = 0; k < NUM_CH; k++) signs_s[k] = i_data[k*DATA_WIDTH + DATA_WIDTH - 1];
  end

  always_comb begin
    sb_in_s.valid = accept_s;
    sb_in_s.mode  = i_mode;
    sb_in_s.sign  = signs_s;
    sb_in_s.raw   = i_data;
  end

  // A write on the accept edge lands after the multipliers have sampled the old alpha.
  always_ff @(posedge clk) begin
    if (rst) begin
      alpha_r <= DEFAULT_ALPHA;
    end else if (cfg_alpha_we) begin
      alpha_r <= cfg_alpha;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LATENCY; i++) sb_r[i] <= '0;
    end else begin
      sb_r[0] <= sb_in_s;
      for (int i = 1; i < MUL_LATENCY; i++) sb_r[i] <= sb_r[i-1];
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_mul
    multiplier_floating_point32 #(.LATENCY(MUL_LATENCY)) u_mul (
      .clk      (clk),
      .rstn     (~rst),
      .valid_in (accept_s),
      .inA      (i_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .inB      (alpha_r),
      .valid_out(mul_valid_unused[k]),
      .out      (prod_s[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    push_data_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      push_data_s[k*DATA_WIDTH +: DATA_WIDTH] = activate(sb_r[MUL_LATENCY-1].mode,
                                                         sb_r[MUL_LATENCY-1].sign[k],
                                                         sb_r[MUL_LATENCY-1].raw[k*DATA_WIDTH +: DATA_WIDTH],
                                                         prod_s[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  activation_out_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .push_data(push_data_s),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .count    (fifo_count_s)
  );

  // Credits: beats in flight plus FIFO occupancy, evaluated on next-state values.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < MUL_LATENCY; i++) inflight_s = inflight_s + TW'(sb_r[i].valid);
    total_next_s = inflight_s + TW'(accept_s) - TW'(push_s)
                 + TW'(fifo_count_s) + TW'(push_s) - TW'(pop_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_ready_r <= 1'b0;
    end else begin
      i_ready_r <= (total_next_s < TW'(FIFO_DEPTH));
    end
  end

`ifdef LRELU_NEG_COUNT_EN
  logic [31:0] neg_count_r;
  logic [32:0] neg_sum_s;

  always_comb begin
    neg_sum_s = {1'b0, neg_count_r};
    if (accept_s) begin
      for (int k = 0; k < NUM_CH; k++) neg_sum_s = neg_sum_s + 33'(signs_s[k]);
    end else begin
      neg_sum_s = {1'b0, neg_count_r};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_count_r <= 32'd0;
    end else if (neg_sum_s[32]) begin
      neg_count_r <= 32'hFFFF_FFFF;
    end else begin
      neg_count_r <= neg_sum_s[31:0];
    end
  end

  assign o_neg_count = neg_count_r;
`else
  assign o_neg_count = 32'h0;
`endif

endmodule

// File: tb/tb_leakyrelu_vector_unit.sv
// Randomized self-checking bench for leakyrelu_vector_unit; the reference model
// computes lane results with real arithmetic and keeps expected beats in a queue.
module tb_leakyrelu_vector_unit;

  localparam int BW = 128;
  localparam logic [31:0] ALPHA_RST = 32'h3DCC_CCCD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [BW-1:0] i_data = '0;
  logic [1:0]    i_mode = 2'd0;
  logic          cfg_alpha_we = 1'b0;
  logic [31:0]   cfg_alpha = 32'd0;
  logic          o_valid;
  logic          o_ready = 1'b1;
  logic [BW-1:0] o_data;
  logic [31:0]   o_neg_count;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_pops = 0;
  logic [BW-1:0] exp_q[$];
  logic [31:0]   model_alpha = ALPHA_RST;
  longint        model_neg = 0;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_data = '0;

  leakyrelu_vector_unit dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .i_mode(i_mode), .cfg_alpha_we(cfg_alpha_we), .cfg_alpha(cfg_alpha),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_neg_count(o_neg_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return $bitstoreal({f[31], 63'd0});
    e = 11'(int'(f[30:23]) - 127 + 1023);
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [23:0] m;
    int          e;
    b = $realtobits(r);
    if (b[62:52] == 11'd0) return {b[63], 31'd0};
    e = int'(b[62:52]) - 1023 + 127;
    m = {1'b0, b[51:29]};
    if (b[28] && ((|b[27:0]) || m[0])) m = m + 24'd1;
    if (m[23]) begin m = 24'd0; e = e + 1; end
    return {b[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [BW-1:0] model_beat(input logic [BW-1:0] d, input logic [1:0] m,
                                               input logic [31:0] a);
    logic [BW-1:0] r;
    logic [31:0]   x;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      x = d[k*32 +: 32];
      if (m == 2'd1 && x[31])      r[k*32 +: 32] = 32'd0;
      else if (m == 2'd2 && x[31]) r[k*32 +: 32] = r2f(f2r(x) * f2r(a));
      else                         r[k*32 +: 32] = x;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_lane();
    logic [31:0] v;
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = 8'($urandom_range(100, 150));
    v[22:0]  = 23'($urandom);
    if ($urandom_range(0, 15) == 0) v[30:0] = 31'd0;
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] d;
    for (int k = 0; k < 4; k++) d[k*32 +: 32] = rand_lane();
    return d;
  endfunction

  // Scoreboard: record accepted beats, compare popped beats, track alpha and stall hold.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_alpha = ALPHA_RST;
      model_neg   = 0;
      prev_stall  = 1'b0;
    end else begin
      if (o_valid && prev_stall) check_eq("stall_hold", o_data, prev_data);
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) check_eq("spurious_out", BW'(o_valid), '0);
        else begin
          check_eq("out_order", o_data, exp_q.pop_front());
          n_pops++;
        end
      end
      prev_stall = o_valid && !o_ready;
      prev_data  = o_data;
      if (i_valid && i_ready) begin
        exp_q.push_back(model_beat(i_data, i_mode, model_alpha));
        for (int k = 0; k < 4; k++) model_neg += longint'(i_data[k*32 + 31]);
        if (model_neg > 64'hFFFF_FFFF) model_neg = 64'hFFFF_FFFF;
      end
      if (cfg_alpha_we) model_alpha = cfg_alpha;
    end
  end

  task automatic send(input logic [BW-1:0] d, input logic [1:0] m);
    bit ok;
    ok = 1'b0;
    i_data = d; i_mode = m; i_valid = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk); ok = i_ready;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    if (!ok) check_eq("send_timeout", BW'(i_ready), BW'(1));
  endtask

  task automatic wait_out(input string tag, output logic [BW-1:0] d);
    bit ok;
    ok = 1'b0; d = '0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (o_valid) begin d = o_data; ok = 1'b1; end
    end
    if (!ok) check_eq({tag, "_timeout"}, BW'(o_valid), BW'(1));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check_eq(tag, BW'(exp_q.size()), '0);
  endtask

  initial begin
    logic [BW-1:0] d;
    logic [BW-1:0] bp_beats [20];
    logic [31:0]   neg_exp;
    int            lat, idx, p0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_o_valid", BW'(o_valid), '0);
    check_eq("rst_o_data", o_data, '0);
    check_eq("rst_i_ready", BW'(i_ready), '0);
    check_eq("rst_neg_count", BW'(o_neg_count), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("ready_after_rst", BW'(i_ready), BW'(1));

    // LeakyReLU with default alpha, latency measured from the accept edge.
    i_data = {32'd0, 32'd0, 32'h3F80_0000, 32'hC000_0000}; i_mode = 2'd2; i_valid = 1'b1;
    @(negedge clk);
    check_eq("ready_first_beat", BW'(i_ready), BW'(1));
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (o_valid) break;
    end
    check_eq("latency", BW'(lat), BW'(8));
    check_eq("lrelu_lane0", BW'(o_data[31:0]), BW'(32'hBE4C_CCCD));
    check_eq("lrelu_lane1", BW'(o_data[63:32]), BW'(32'h3F80_0000));
    @(posedge clk); #1;

    send({32'h0000_0000, 32'h4040_0000, 32'h8000_0000, 32'hC000_0000}, 2'd1);
    wait_out("relu", d);
    check_eq("relu_beat", d, {32'h0, 32'h4040_0000, 32'h0, 32'h0});
    send({32'h0000_0000, 32'h4040_0000, 32'h8000_0000, 32'hC000_0000}, 2'd0);
    wait_out("bypass", d);
    check_eq("bypass_beat", d, {32'h0000_0000, 32'h4040_0000, 32'h8000_0000, 32'hC000_0000});

    // Alpha update between two beats.
    send({96'd0, 32'hC000_0000}, 2'd2);
    cfg_alpha = 32'h3F00_0000; cfg_alpha_we = 1'b1;
    @(posedge clk); #1;
    cfg_alpha_we = 1'b0;
    send({96'd0, 32'hC000_0000}, 2'd2);
    wait_out("alpha_a", d);
    check_eq("alpha_old", BW'(d[31:0]), BW'(32'hBE4C_CCCD));
    wait_out("alpha_b", d);
    check_eq("alpha_new", BW'(d[31:0]), BW'(32'hBF80_0000));

    // Backpressure: 20 beats offered with the output stalled.
    for (int b = 0; b < 20; b++) bp_beats[b] = rand_beat();
    p0 = n_pops;
    o_ready = 1'b0; idx = 0;
    i_data = bp_beats[0]; i_mode = 2'($urandom_range(0, 3)); i_valid = 1'b1;
    for (int c = 0; c < 240 && idx < 20; c++) begin
      bit acc;
      if (c == 40) begin
        check_eq("bp_accepted", BW'(idx), BW'(8));
        check_eq("bp_ready_low", BW'(i_ready), '0);
        o_ready = 1'b1;
      end
      @(negedge clk); acc = i_valid && i_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 20) begin i_data = bp_beats[idx]; i_mode = 2'($urandom_range(0, 3)); end
      end
    end
    i_valid = 1'b0;
    drain("bp_drain");
    check_eq("bp_count", BW'(n_pops - p0), BW'(20));

    // Reset with beats in flight discards them.
    for (int b = 0; b < 5; b++) send(rand_beat(), 2'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_flight_valid", BW'(o_valid), '0);
    check_eq("rst_flight_data", o_data, '0);
    rst = 1'b0;
    p0 = n_pops;
    @(posedge clk); #1;
    check_eq("rst_flight_ready", BW'(i_ready), BW'(1));
    repeat (20) @(posedge clk);
    #1;
    check_eq("no_stale", BW'(n_pops - p0), '0);

    // Three beats with two negative lanes each.
    for (int b = 0; b < 3; b++) begin
      d = rand_beat();
      d[31] = 1'b1; d[63] = 1'b1; d[95] = 1'b0; d[127] = 1'b0;
      send(d, 2'd2);
    end
`ifdef LRELU_NEG_COUNT_EN
    neg_exp = 32'd6;
`else
    neg_exp = 32'd0;
`endif
    check_eq("neg_count_3", BW'(o_neg_count), BW'(neg_exp));

    // Randomized traffic with random backpressure and alpha writes.
    for (int c = 0; c < 400; c++) begin
      i_valid = ($urandom_range(0, 9) < 7);
      i_data  = rand_beat();
      i_mode  = 2'($urandom_range(0, 3));
      o_ready = ($urandom_range(0, 3) != 0);
      cfg_alpha_we = ($urandom_range(0, 19) == 0);
      cfg_alpha = {1'b0, 8'($urandom_range(115, 128)), 23'($urandom)};
      @(posedge clk); #1;
    end
    i_valid = 1'b0; cfg_alpha_we = 1'b0; o_ready = 1'b1;
    drain("rand_drain");
`ifdef LRELU_NEG_COUNT_EN
    neg_exp = 32'(model_neg);
`else
    neg_exp = 32'd0;
`endif
    check_eq("neg_count_final", BW'(o_neg_count), BW'(neg_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
